regfile_write_ctrl: RTL and testbench
=====================================

Name: regfile_write_ctrl

Overview:
Write-port controller for the 32x32 three-port register file of the single-cycle core. It owns the file's single write port (we3/a3/wd3).
- After reset, it sequences a clear of x1..x31.
- In normal operation, it arbitrates that port between core writeback and a debug/loader requester.
- Writeback has priority; a starvation limit forces a debug grant by stalling the core for one cycle.

Parameters:
XLEN, 32, data width of register file words
ADDR_W, 5, register address width (32 registers)
MAX_WAIT, 4, consecutive cycles a pending debug request may be blocked before a forced grant (1..15)
CLEAR_VALUE, 32'h0, value written to x1..x31 during the clear sequence

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wb_we  in  1  core writeback write enable
wb_addr  in  ADDR_W  core writeback destination register
wb_data  in  XLEN  core writeback data
dbg_req  in  1  debug write request; held with addr/data until dbg_ack
dbg_addr  in  ADDR_W  debug destination register
dbg_data  in  XLEN  debug write data
dbg_ack  out  1  one-cycle pulse; debug write commits at the end of this cycle
core_stall  out  1  core must not retire/advance PC this cycle
we3  out  1  register file write enable
a3  out  ADDR_W  register file write address
wd3  out  XLEN  register file write data
init_done  out  1  high once the clear sequence has completed

Behaviour:
- State is registered: fsm {CLEAR, RUN}, clr_idx[ADDR_W], wait_cnt[4]. Outputs are combinational from state plus inputs.
- Reset high at a clock edge: fsm<=CLEAR, clr_idx<=1, wait_cnt<=0.
- While reset is high: we3=0, a3=0, wd3=0, dbg_ack=0, core_stall=1, init_done=0.
- CLEAR:
  - Drive we3=1, a3=clr_idx, wd3=CLEAR_VALUE, core_stall=1, dbg_ack=0, init_done=0.
  - Each cycle clr_idx++. The cycle writing a3=31 transitions to RUN, so exactly 31 write cycles.
  - dbg_req is ignored and no ack is given.
- RUN:
  - init_done=1.
  - wb_act = wb_we && wb_addr!=0.
  - dbg_act = dbg_req && dbg_addr!=0.
  - forced = dbg_req && wait_cnt==MAX_WAIT. It depends only on registered state and dbg_req, never on wb_*, so there is no combinational loop through the core.
- Grant priority in RUN, evaluated each cycle:
  1. forced: debug granted. core_stall=1, dbg_ack=1, we3=dbg_act, a3=dbg_addr, wd3=dbg_data. The core's writeback is discarded because the core is stalled.
  2. wb_act: writeback granted. we3=1, a3=wb_addr, wd3=wb_data, core_stall=0. If dbg_req, wait_cnt++, saturating at MAX_WAIT.
  3. dbg_req: debug granted. dbg_ack=1, core_stall=0, we3=dbg_act, a3=dbg_addr, wd3=dbg_data.
  4. Otherwise: we3=0, a3=0, wd3=0, core_stall=0.
- wait_cnt<=0 on any debug grant, or on any cycle with dbg_req=0.
- Writes to x0 from either source never assert we3.
  - wb_we with wb_addr=0 does not block debug.
  - A debug request to x0 is still acked (no write).
- Latency:
  - Writeback commits on the same edge it is presented.
  - Debug commits within at most MAX_WAIT+1 cycles of dbg_req rising in RUN.
- Back-to-back debug requests:
  - dbg_req may stay high after an ack with new addr/data.
  - The next grant is evaluated fresh the following cycle.
- Reset mid-CLEAR restarts at clr_idx=1. Reset mid-RUN discards pending debug (no ack) and re-runs CLEAR.

Optional Feature:
Macro REGFILE_CLEAR_EN.
- Defined: the CLEAR sequence above is compiled in.
- Undefined:
  - The CLEAR state and clr_idx are removed, and reset goes directly to RUN.
  - The first cycle after reset deasserts has init_done=1 and core_stall governed only by the arbitration rules.
  - Register contents are left as-is.

Test Plan:
- Clear: REGFILE_CLEAR_EN defined, CLEAR_VALUE=0. Assert reset 2 cycles, release.
  - Response: 31 cycles of we3=1, a3=1..31, wd3=0, core_stall=1, then init_done=1.
  - Reading x5 afterwards returns 0.
- Writeback: in RUN, wb_we=1, wb_addr=1, wb_data=32'h12345678, dbg_req=0.
  - Response: we3=1, a3=1, wd3=32'h12345678, core_stall=0 that cycle.
  - rd1 with a1=1 reads 32'h12345678 next cycle.
- Debug idle grant: wb_we=0, dbg_req=1, dbg_addr=2, dbg_data=32'h87654321.
  - Response: dbg_ack=1 the same cycle, we3=1, a3=2.
  - Register 2 reads 32'h87654321.
- Starvation: MAX_WAIT=4, wb_we=1 every cycle to x3, dbg_req=1 to x4 with 32'hdeadbeef.
  - Response: 4 cycles of writeback grants.
  - 5th cycle: core_stall=1, dbg_ack=1, a3=4, wd3=32'hdeadbeef, then wait_cnt=0.
- x0 handling: dbg_req=1, dbg_addr=0, dbg_data=32'hdeadbeef.
  - Response: dbg_ack=1, we3=0, x0 reads 0.
  - wb_we=1 with wb_addr=0 alongside a debug request to x6: debug granted the same cycle.
- Reset mid-CLEAR: reset at clr_idx=10 for 1 cycle.
  - Response: the sequence restarts at a3=1 and completes 31 writes before init_done=1.
  - A dbg_req held throughout is acked only after init_done rises.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the 32x32 register file: post-reset clear of x1..x31,
// then writeback/debug arbitration with a starvation-forced debug grant.
// Optional clear sequence is compiled in with REGFILE_CLEAR_EN.
module regfile_write_ctrl #(
   parameter int                XLEN        = 32,
   parameter int                ADDR_W      = 5,
   parameter int                MAX_WAIT    = 4,
   parameter logic [XLEN-1:0]   CLEAR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [XLEN-1:0]   dbg_data,
   output logic              dbg_ack,
   output logic              core_stall,
   output logic              we3,
   output logic [ADDR_W-1:0] a3,
   output logic [XLEN-1:0]   wd3,
   output logic              init_done
);

   logic [3:0] wait_cnt_reg, wait_cnt_next;
   logic       run_mode;
   logic       wb_act, dbg_act, forced;

`ifdef REGFILE_CLEAR_EN
   typedef enum logic {CLEAR, RUN} state_t;

   state_t            fsm_reg, fsm_next;
   logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_reg     <= CLEAR;
         clr_idx_reg <= ADDR_W'(1);
      end else begin
         fsm_reg     <= fsm_next;
         clr_idx_reg <= clr_idx_next;
      end
   end

   always_comb begin
      fsm_next     = fsm_reg;
      clr_idx_next = clr_idx_reg;
      if (fsm_reg == CLEAR) begin
         clr_idx_next = clr_idx_reg + ADDR_W'(1);
         // The cycle that writes the top register is the last clear write.
         if (clr_idx_reg == {ADDR_W{1'b1}})
            fsm_next = RUN;
      end
   end

   assign run_mode = (fsm_reg == RUN);
`else
   assign run_mode = 1'b1;
`endif

   assign wb_act  = wb_we && (wb_addr != '0);
   assign dbg_act = dbg_req && (dbg_addr != '0);
   // Deliberately independent of wb_* so the core's stall never loops back into it.
   assign forced  = run_mode && dbg_req && (wait_cnt_reg == 4'(MAX_WAIT));

   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt_reg <= '0;
      else
         wait_cnt_reg <= wait_cnt_next;
   end

   always_comb begin
      wait_cnt_next = '0;
      if (run_mode && dbg_req && !forced && wb_act) begin
         if (wait_cnt_reg < 4'(MAX_WAIT))
            wait_cnt_next = wait_cnt_reg + 4'd1;
         else
            wait_cnt_next = wait_cnt_reg;
      end
   end

   always_comb begin
      we3        = 1'b0;
      a3         = '0;
      wd3        = '0;
      dbg_ack    = 1'b0;
      core_stall = 1'b0;
      init_done  = 1'b0;
      if (reset) begin
         core_stall = 1'b1;
      end
`ifdef REGFILE_CLEAR_EN
      else if (fsm_reg == CLEAR) begin
         we3        = 1'b1;
         a3         = clr_idx_reg;
         wd3        = CLEAR_VALUE;
         core_stall = 1'b1;
      end
`endif
      else begin
         init_done = 1'b1;
         if (forced) begin
            core_stall = 1'b1;
            dbg_ack    = 1'b1;
            we3        = dbg_act;
            a3         = dbg_addr;
            wd3        = dbg_data;
         end else if (wb_act) begin
            we3 = 1'b1;
            a3  = wb_addr;
            wd3 = wb_data;
         end else if (dbg_req) begin
            dbg_ack = 1'b1;
            we3     = dbg_act;
            a3      = dbg_addr;
            wd3     = dbg_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: stimulus queues expected port values,
// a negedge monitor pops and compares; a small register-file model checks reads.
module tb_regfile_write_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        dbg_req = 1'b0;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_data = '0;
   logic        dbg_ack, core_stall, we3, init_done;
   logic [4:0]  a3;
   logic [31:0] wd3;

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      string       nm;
      logic [40:0] v;
   } exp_t;

   exp_t exp_q[$];
   logic [31:0] rf [32];

   regfile_write_ctrl #(.XLEN(32), .ADDR_W(5), .MAX_WAIT(4), .CLEAR_VALUE(32'h0)) dut (
      .clk(clk), .reset(reset),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .dbg_ack(dbg_ack), .core_stall(core_stall),
      .we3(we3), .a3(a3), .wd3(wd3), .init_done(init_done)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'ha5a50000 + i;
   end

   always @(posedge clk) if (we3) rf[a3] <= wd3;

   function automatic logic [40:0] ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                                      input logic ack, input logic st, input logic ini);
      return {we, a, d, ack, st, ini};
   endfunction

   task automatic check(input string nm, input logic [40:0] act, input logic [40:0] req);
      n_chk++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got we3/a3/wd3/ack/stall/init=%h required %h", nm, act, req);
      end else begin
         $display("ok   %s: we3/a3/wd3/ack/stall/init=%h", nm, act);
      end
   endtask

   task automatic check_rf(input string nm, input int idx, input logic [31:0] req);
      n_chk++;
      if (rf[idx] !== req) begin
         n_bad++;
         $display("FAIL %s: x%0d got %h required %h", nm, idx, rf[idx], req);
      end else begin
         $display("ok   %s: x%0d=%h", nm, idx, rf[idx]);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.nm, {we3, a3, wd3, dbg_ack, core_stall, init_done}, e.v);
      end
   end

   task automatic step(input string nm, input logic r,
                       input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic dq, input logic [4:0] da, input logic [31:0] dd,
                       input logic [40:0] ev);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; wb_we = wwe; wb_addr = wa; wb_data = wd;
      dbg_req = dq; dbg_addr = da; dbg_data = dd;
      e.nm = nm;
      e.v  = ev;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string nm);
      step(nm, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ex(0, 0, 0, 0, 0, 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [40:0] rst_v;
      rst_v = ex(0, 0, 0, 0, 1, 0);
      step("reset0", 1, 0, 0, 0, 0, 0, 0, rst_v);
      step("reset1", 1, 0, 0, 0, 0, 0, 0, rst_v);
`ifdef REGFILE_CLEAR_EN
      for (int i = 1; i <= 31; i++)
         step($sformatf("clear a3=%0d", i), 0, 0, 0, 0, 0, 0, 0, ex(1, 5'(i), 0, 0, 1, 0));
`endif
      step("wb x1", 0, 1, 5'd1, 32'h12345678, 0, 0, 0, ex(1, 5'd1, 32'h12345678, 0, 0, 1));
      idle("idle after wb");
`ifdef REGFILE_CLEAR_EN
      check_rf("cleared x5", 5, 32'h0);
`endif
      check_rf("rd x1", 1, 32'h12345678);
      step("dbg idle x2", 0, 0, 0, 0, 1, 5'd2, 32'h87654321, ex(1, 5'd2, 32'h87654321, 1, 0, 1));
      idle("idle after dbg");
      check_rf("rd x2", 2, 32'h87654321);

      // Starvation: four writeback wins, then the forced grant.
      for (int k = 0; k < 4; k++)
         step($sformatf("starve wb %0d", k), 0, 1, 5'd3, 32'h30 + k, 1, 5'd4, 32'hdeadbeef,
              ex(1, 5'd3, 32'h30 + k, 0, 0, 1));
      step("starve forced", 0, 1, 5'd3, 32'h34, 1, 5'd4, 32'hdeadbeef,
           ex(1, 5'd4, 32'hdeadbeef, 1, 1, 1));
      step("post-force wb", 0, 1, 5'd3, 32'h35, 1, 5'd4, 32'hcafef00d,
           ex(1, 5'd3, 32'h35, 0, 0, 1));
      idle("idle after starve");
      check_rf("rd x4", 4, 32'hdeadbeef);
      check_rf("rd x3", 3, 32'h35);

      // Dropping dbg_req clears the wait count, so the force needs four fresh blocked cycles.
      step("drop wb a", 0, 1, 5'd3, 32'h40, 1, 5'd8, 32'h88, ex(1, 5'd3, 32'h40, 0, 0, 1));
      step("drop wb b", 0, 1, 5'd3, 32'h41, 1, 5'd8, 32'h88, ex(1, 5'd3, 32'h41, 0, 0, 1));
      step("drop gap", 0, 1, 5'd3, 32'h42, 0, 5'd8, 32'h88, ex(1, 5'd3, 32'h42, 0, 0, 1));
      for (int k = 0; k < 4; k++)
         step($sformatf("drop wb %0d", k), 0, 1, 5'd3, 32'h50 + k, 1, 5'd8, 32'h88,
              ex(1, 5'd3, 32'h50 + k, 0, 0, 1));
      step("drop forced", 0, 1, 5'd3, 32'h54, 1, 5'd8, 32'h88, ex(1, 5'd8, 32'h88, 1, 1, 1));

      step("dbg x0", 0, 0, 0, 0, 1, 5'd0, 32'hdeadbeef, ex(0, 5'd0, 32'hdeadbeef, 1, 0, 1));
      step("wb x0 + dbg x6", 0, 1, 5'd0, 32'h55, 1, 5'd6, 32'h66666666,
           ex(1, 5'd6, 32'h66666666, 1, 0, 1));
      idle("idle after x0");
      check_rf("rd x0", 0, 32'h0);
      check_rf("rd x6", 6, 32'h66666666);

      // Reset in RUN with a pending debug request: no ack while in reset.
      step("reset run", 1, 0, 0, 0, 1, 5'd7, 32'h77, rst_v);
`ifdef REGFILE_CLEAR_EN
      for (int i = 1; i <= 9; i++)
         step($sformatf("clr1 a3=%0d", i), 0, 0, 0, 0, 1, 5'd7, 32'h77, ex(1, 5'(i), 0, 0, 1, 0));
      step("reset mid-clear", 1, 0, 0, 0, 1, 5'd7, 32'h77, rst_v);
      for (int i = 1; i <= 31; i++)
         step($sformatf("clr2 a3=%0d", i), 0, 0, 0, 0, 1, 5'd7, 32'h77, ex(1, 5'(i), 0, 0, 1, 0));
`endif
      step("dbg x7 after init", 0, 0, 0, 0, 1, 5'd7, 32'h77, ex(1, 5'd7, 32'h77, 1, 0, 1));
      idle("final idle");
      check_rf("rd x7", 7, 32'h77);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_chk++;
         n_bad++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
